// File: rtl/crossing_pkg.sv
// Shared definitions for the river-crossing monitor: FSM encoding,
// bank start/goal constants and the step counter width.
package crossing_pkg;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_WAIT_RESTART = 2'd1,
    ST_ERROR        = 2'd2,
    ST_TIMEOUT      = 2'd3
  } mon_state_e;

  localparam logic [1:0] START_M = 2'd3;
  localparam logic [1:0] START_C = 2'd3;
  localparam logic [1:0] GOAL_M  = 2'd0;
  localparam logic [1:0] GOAL_C  = 2'd0;
  localparam int unsigned STEP_W = 5;

  // Pack a start-bank population into the {m,c} nibble used everywhere.
  function automatic logic [3:0] bank_pack(input logic [1:0] m, input logic [1:0] c);
    return {m, c};
  endfunction

  localparam logic [3:0] START_BANK = {START_M, START_C};
  localparam logic [3:0] GOAL_BANK  = {GOAL_M, GOAL_C};

endpackage

// File: rtl/move_checker.sv
// Combinational legality check for one boat trip between two start-bank
// populations, given the direction the boat is travelling.
module move_checker
  import crossing_pkg::*;
(
  input  logic [3:0] prev,
  input  logic [3:0] sample,
  input  logic       dir,
  output logic       legal
);

  logic [1:0] pm, pc, sm, sc;
  logic [1:0] far_m, far_c;
  logic [2:0] delta;
  logic       mono, safe_start, safe_far;

  // Boat moves people off the start bank when dir=0, back onto it when dir=1;
  // the boat carries one or two and both banks must stay safe afterwards.
  always_comb begin
    pm    = prev[3:2];
    pc    = prev[1:0];
    sm    = sample[3:2];
    sc    = sample[1:0];
    far_m = START_M - sm;
    far_c = START_C - sc;
    if (!dir) begin
      mono  = (sm <= pm) && (sc <= pc);
      delta = {1'b0, pm - sm} + {1'b0, pc - sc};
    end else begin
      mono  = (sm >= pm) && (sc >= pc);
      delta = {1'b0, sm - pm} + {1'b0, sc - pc};
    end
    safe_start = (sm == 2'd0) || (sm >= sc);
    safe_far   = (far_m == 2'd0) || (far_m >= far_c);
    legal      = mono && ((delta == 3'd1) || (delta == 3'd2)) && safe_start && safe_far;
  end

endmodule

// File: rtl/crossing_monitor.sv
// Watches a missionaries-and-cannibals solver one sample at a time,
// validating every move, counting solved rounds and flagging errors.
module crossing_monitor
  import crossing_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        missionary_next,
  input  logic [1:0]        cannibal_next,
  input  logic              finish,
  output logic [STEP_W-1:0] step_count,
  output logic              solved,
  output logic [STEP_W-1:0] solve_steps,
  output logic [7:0]        rounds,
  output logic              illegal,
  output logic [3:0]        illegal_state,
  output logic              finish_err,
  output logic [1:0]        mon_state
);

  localparam logic [STEP_W-1:0] MAX_STEPS_W = STEP_W'(MAX_STEPS);

  mon_state_e        state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              solved_q, solved_d;
  logic [STEP_W-1:0] solve_steps_q, solve_steps_d;
  logic [7:0]        rounds_q, rounds_d;
  logic              illegal_q, illegal_d;
  logic [3:0]        illegal_state_q, illegal_state_d;
  logic              finish_err_q, finish_err_d;

  logic [3:0]        sample;
  logic              legal;
  logic              goal_arrival;
  logic [STEP_W-1:0] step_inc;

  assign sample = bank_pack(missionary_next, cannibal_next);

  move_checker u_move_checker (
    .prev   (prev_q),
    .sample (sample),
    .dir    (dir_q),
    .legal  (legal)
  );

  // Goal detection and the saturating step increment used by a legal move.
  always_comb begin
    goal_arrival = (state_q == ST_RUN) && legal && (sample == GOAL_BANK);
    step_inc     = (step_q == '1) ? step_q : step_q + STEP_W'(1);
  end

  // Next-state and output computation; solved is a single-cycle pulse.
  always_comb begin
    state_d         = state_q;
    prev_d          = prev_q;
    dir_d           = dir_q;
    step_d          = step_q;
    solved_d        = 1'b0;
    solve_steps_d   = solve_steps_q;
    rounds_d        = rounds_q;
    illegal_d       = illegal_q;
    illegal_state_d = illegal_state_q;
    finish_err_d    = finish_err_q;

    if (in_valid && (state_q != ST_ERROR)) begin
      // The solver's finish flag must match our own view of a goal arrival.
      if (finish != goal_arrival) begin
        finish_err_d = 1'b1;
      end

      case (state_q)
        ST_RUN: begin
          if (legal) begin
            prev_d = sample;
            dir_d  = ~dir_q;
            step_d = step_inc;
            if (goal_arrival) begin
              solved_d      = 1'b1;
              solve_steps_d = step_inc;
              rounds_d      = rounds_q + 8'd1;
              state_d       = ST_WAIT_RESTART;
            end else if (step_inc >= MAX_STEPS_W) begin
              state_d = ST_TIMEOUT;
            end
          end else begin
            if (!illegal_q) illegal_state_d = sample;
            illegal_d = 1'b1;
            state_d   = ST_ERROR;
          end
        end
        ST_WAIT_RESTART: begin
          if (sample == START_BANK) begin
            prev_d  = START_BANK;
            dir_d   = 1'b0;
            step_d  = '0;
            state_d = ST_RUN;
          end else begin
            if (!illegal_q) illegal_state_d = sample;
            illegal_d = 1'b1;
            state_d   = ST_ERROR;
          end
        end
        default: begin
          // TIMEOUT is terminal: only the finish cross-check above stays live.
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      prev_q          <= START_BANK;
      dir_q           <= 1'b0;
      step_q          <= '0;
      solved_q        <= 1'b0;
      solve_steps_q   <= '0;
      rounds_q        <= '0;
      illegal_q       <= 1'b0;
      illegal_state_q <= '0;
      finish_err_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_q          <= prev_d;
      dir_q           <= dir_d;
      step_q          <= step_d;
      solved_q        <= solved_d;
      solve_steps_q   <= solve_steps_d;
      rounds_q        <= rounds_d;
      illegal_q       <= illegal_d;
      illegal_state_q <= illegal_state_d;
      finish_err_q    <= finish_err_d;
    end
  end

  assign step_count    = step_q;
  assign solved        = solved_q;
  assign solve_steps   = solve_steps_q;
  assign rounds        = rounds_q;
  assign illegal       = illegal_q;
  assign illegal_state = illegal_state_q;
  assign finish_err    = finish_err_q;
  assign mon_state     = state_q;

endmodule

// File: tb/tb_crossing_monitor.sv
// Scoreboard bench for crossing_monitor: a behavioural model pushes the
// expected outputs for every driven sample; they are popped and compared
// half a clock after the edge that consumes the sample.
module tb_crossing_monitor;
  import crossing_pkg::*;

  localparam int MAX = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [1:0] mn, cn;
  logic       finish;
  logic [4:0] step_count, solve_steps;
  logic       solved, illegal, finish_err;
  logic [7:0] rounds;
  logic [3:0] illegal_state;
  logic [1:0] mon_state;

  crossing_monitor #(.MAX_STEPS(MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .missionary_next (mn),
    .cannibal_next   (cn),
    .finish          (finish),
    .step_count      (step_count),
    .solved          (solved),
    .solve_steps     (solve_steps),
    .rounds          (rounds),
    .illegal         (illegal),
    .illegal_state   (illegal_state),
    .finish_err      (finish_err),
    .mon_state       (mon_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int solved;
    int solve_steps;
    int rounds;
    int illegal;
    int illegal_state;
    int finish_err;
    int state;
  } exp_t;

  exp_t mdl;
  exp_t sb_q[$];
  int   pm, pc, mdir;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check_value("step_count",    32'(step_count),    e.step);
    check_value("solved",        32'(solved),        e.solved);
    check_value("solve_steps",   32'(solve_steps),   e.solve_steps);
    check_value("rounds",        32'(rounds),        e.rounds);
    check_value("illegal",       32'(illegal),       e.illegal);
    check_value("illegal_state", 32'(illegal_state), e.illegal_state);
    check_value("finish_err",    32'(finish_err),    e.finish_err);
    check_value("mon_state",     32'(mon_state),     e.state);
  endtask

  task automatic model_reset();
    pm = 3; pc = 3; mdir = 0;
    mdl = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  // Boat trip model: count people carried and check both banks.
  function automatic bit model_legal(input int sm, input int sc);
    int carried_m, carried_c;
    carried_m = (mdir == 0) ? pm - sm : sm - pm;
    carried_c = (mdir == 0) ? pc - sc : sc - pc;
    if (carried_m < 0 || carried_c < 0) return 1'b0;
    if (carried_m + carried_c < 1 || carried_m + carried_c > 2) return 1'b0;
    if (sm != 0 && sm < sc) return 1'b0;
    if ((3 - sm) != 0 && (3 - sm) < (3 - sc)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mark_illegal(input int m, input int c);
    if (mdl.illegal == 0) mdl.illegal_state = m * 4 + c;
    mdl.illegal = 1;
    mdl.state   = 2;
  endtask

  task automatic model_step(input bit v, input int m, input int c, input bit f);
    bit ok, goal;
    mdl.solved = 0;
    if (!v || mdl.state == 2) return;
    ok   = model_legal(m, c);
    goal = (mdl.state == 0) && ok && m == 0 && c == 0;
    if (f != goal) mdl.finish_err = 1;
    if (mdl.state == 0) begin
      if (ok) begin
        pm = m; pc = c; mdir = 1 - mdir;
        if (mdl.step < 31) mdl.step++;
        if (goal) begin
          mdl.solved      = 1;
          mdl.solve_steps = mdl.step;
          mdl.rounds      = (mdl.rounds + 1) % 256;
          mdl.state       = 1;
        end else if (mdl.step >= MAX) begin
          mdl.state = 3;
        end
      end else begin
        mark_illegal(m, c);
      end
    end else if (mdl.state == 1) begin
      if (m == 3 && c == 3) begin
        pm = 3; pc = 3; mdir = 0; mdl.step = 0; mdl.state = 0;
      end else begin
        mark_illegal(m, c);
      end
    end
  endtask

  // Drive one sample at the falling edge, let the rising edge consume it,
  // then compare against the scoreboard at the next falling edge.
  task automatic apply(input bit v, input int m, input int c, input bit f);
    exp_t e;
    in_valid = v;
    mn       = m[1:0];
    cn       = c[1:0];
    finish   = f;
    model_step(v, m, c, f);
    sb_q.push_back(mdl);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    compare_outputs(e);
    $display("sample v=%0d m=%0d c=%0d fin=%0d -> step=%0d state=%0d solved=%0d",
             v, m, c, f, step_count, mon_state, solved);
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b0;
    in_valid = 1'b0;
    finish = 1'b0;
    model_reset();
    sb_q.push_back(mdl);
    @(negedge clk);
    e = sb_q.pop_front();
    compare_outputs(e);
    reset = 1'b1;
  endtask

  int seq[11] = '{'h31, 'h32, 'h30, 'h31, 'h11, 'h22, 'h02, 'h03, 'h01, 'h02, 'h00};

  initial begin
    exp_t e;
    reset = 1'b0; in_valid = 1'b0; mn = '0; cn = '0; finish = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Optimal 11-move solution, finish only on the arrival.
    for (int i = 0; i < 11; i++) apply(1'b1, seq[i] >> 4, seq[i] & 15, i == 10);
    check_value("opt_solve_steps", 32'(solve_steps), 11);
    check_value("opt_rounds", 32'(rounds), 1);
    check_value("opt_illegal", 32'(illegal), 0);
    apply(1'b0, 0, 0, 1'b0);

    // Restart then one move.
    apply(1'b1, 3, 3, 1'b0);
    apply(1'b1, 3, 1, 1'b0);
    check_value("restart_state", 32'(mon_state), 0);
    check_value("restart_step", 32'(step_count), 1);
    check_value("restart_rounds", 32'(rounds), 1);

    // Second solve with finish held low on arrival.
    for (int i = 1; i < 11; i++) apply(1'b1, seq[i] >> 4, seq[i] & 15, 1'b0);
    check_value("nofinish_err", 32'(finish_err), 1);
    check_value("nofinish_rounds", 32'(rounds), 2);

    // Start-bank safety violation then ignored samples.
    do_reset();
    apply(1'b1, 1, 3, 1'b0);
    check_value("unsafe_state_cap", 32'(illegal_state), 4'b0111);
    check_value("unsafe_mon_state", 32'(mon_state), 2);
    apply(1'b1, 3, 1, 1'b0);
    apply(1'b1, 2, 2, 1'b1);

    // Wrong direction on the return trip.
    do_reset();
    apply(1'b1, 3, 1, 1'b0);
    apply(1'b1, 3, 0, 1'b0);
    check_value("wrongdir_illegal", 32'(illegal), 1);
    check_value("wrongdir_step", 32'(step_count), 1);

    // Legal shuttle until the step budget runs out.
    do_reset();
    for (int i = 0; i < MAX; i++) apply(1'b1, 3, (i % 2 == 0) ? 1 : 3, 1'b0);
    check_value("timeout_state", 32'(mon_state), 3);
    check_value("timeout_step", 32'(step_count), MAX);
    apply(1'b1, 3, 1, 1'b1);
    check_value("timeout_finish_err", 32'(finish_err), 1);

    // Stalls hold state, then an asynchronous reset mid-round.
    do_reset();
    for (int i = 0; i < 5; i++) apply(1'b1, seq[i] >> 4, seq[i] & 15, 1'b0);
    apply(1'b0, 0, 0, 1'b1);
    apply(1'b0, 1, 2, 1'b0);
    check_value("stall_step", 32'(step_count), 5);
    #2;
    reset = 1'b0;
    model_reset();
    sb_q.push_back(mdl);
    #1;
    e = sb_q.pop_front();
    compare_outputs(e);
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 3, 1, 1'b0);
    check_value("post_reset_step", 32'(step_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/crossing_monitor.md
CROSSING_MONITOR -- requirements
Module: crossing_monitor

Interface
REQ-001 Parameter MAX_STEPS, default 15, is the step budget per round; a round that reaches MAX_STEPS without solving ends in TIMEOUT.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  the sample on missionary_next/cannibal_next/finish is consumed this cycle; tied high when the solver advances every clock.
REQ-005 missionary_next  input  2  solver's next start-bank missionary count, 0..3.
REQ-006 cannibal_next  input  2  solver's next start-bank cannibal count, 0..3.
REQ-007 finish  input  1  solver's finish flag, checked against the monitor's own goal detection.
REQ-008 step_count  output  5  legal moves accepted in the current round.
REQ-009 solved  output  1  one-cycle pulse when a round reaches (0,0) legally.
REQ-010 solve_steps  output  5  step count of the most recent solved round; held until the next solve.
REQ-011 rounds  output  8  completed solved rounds; wraps 255->0.
REQ-012 illegal  output  1  sticky; the first illegal transition was seen.
REQ-013 illegal_state  output  4  offending sample {m,c}, captured once.
REQ-014 finish_err  output  1  sticky; the finish input disagreed with goal detection.
REQ-015 mon_state  output  2  encoded FSM state.

Function
REQ-016 The block keeps an internal previous-state register prev={m,c} and a boat-direction bit dir (0 = boat leaves the start bank).
REQ-017 Each sample with in_valid=1 in RUN is a legal move only if all of the following hold:
  - dir=0: m and c are each non-increasing, and the total decrease is 1 or 2.
  - dir=1: m and c are each non-decreasing, and the total increase is 1 or 2.
  - Start-bank safety: m=0 or m>=c.
  - Far-bank safety: 3-m=0 or 3-m>=3-c.
REQ-018 A legal move sets prev to the sample, toggles dir and increments step_count.
REQ-019 A legal move whose sample is (0,0) pulses solved for one cycle and loads solve_steps with the new step_count.
REQ-020 A legal move whose sample is (0,0) also increments rounds and moves the FSM to WAIT_RESTART.
REQ-021 finish_err sets when finish=1 on a sample other than a legal (0,0) arrival.
REQ-022 finish_err also sets when finish=0 on a legal (0,0) arrival.
REQ-023 In WAIT_RESTART, a valid sample of (3,3) reloads prev=(3,3), dir=0 and step_count=0, and returns the FSM to RUN; this sample is not counted as a move.
REQ-024 In WAIT_RESTART, any other valid sample is illegal.
REQ-025 Any illegal sample sets illegal, captures illegal_state (only if illegal was clear) and moves the FSM to ERROR; ERROR holds until reset, all counters freeze and later samples are ignored.
REQ-026 If step_count reaches MAX_STEPS without solving, the FSM enters TIMEOUT, which is terminal until reset; an arrival at (0,0) on exactly step MAX_STEPS counts as solved, not as a timeout.
REQ-027 in_valid=0 changes no state.
REQ-028 FSM states:
  - RUN=0
  - WAIT_RESTART=1
  - ERROR=2
  - TIMEOUT=3
REQ-029 All outputs are registered, with one cycle of latency from the accepted sample; step_count saturates and never wraps.

Reset
REQ-030 While reset=0 the outputs and registers take these values:
  - prev=(3,3), dir=0, mon_state=RUN
  - step_count=0, solve_steps=0, rounds=0
  - solved=0, illegal=0, illegal_state=0, finish_err=0
REQ-031 Reset asserted mid-round abandons the round immediately, with no solved pulse and no error.

Structure
REQ-032 Shared package crossing_pkg holds the FSM state enum, START_M=3, START_C=3, GOAL=(0,0) and the 5-bit step width.
REQ-033 The legality check lives in one combinational sub-module, move_checker: inputs prev, sample, dir; output legal.

Verification
REQ-034 Optimal sequence 31,32,30,31,11,22,02,03,01,02,00 from reset, with finish=1 on 00 only -> solved pulses on the 11th sample, solve_steps=11, rounds=1, illegal=0.
REQ-035 After that solve, sample 33 then 31 -> FSM returns to RUN, step_count=1, rounds stays 1.
REQ-036 From reset, sample 13 (start-bank safety violation) -> illegal=1, illegal_state=4'b0111, mon_state=ERROR; subsequent samples change nothing.
REQ-037 From reset, sample 31 then 30 (wrong direction on the return move) -> illegal=1 on the second sample, step_count=1.
REQ-038 Legal shuttle 31,33 repeated past MAX_STEPS=15 -> mon_state=TIMEOUT with step_count=15; sample 31 with finish=1 -> finish_err=1.
REQ-039 Assert reset mid-round after 5 moves -> all outputs return to their reset values asynchronously with no solved pulse; in_valid=0 stalls hold step_count.
